// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Credit-based instruction fetch unit. Issues word-aligned reads to
//            an in-order, variable-latency instruction memory and buffers the
//            returned words (with their addresses) in a small FIFO for decode.
//            A redirect flushes the buffer and discards in-flight responses.
// Ports    : clock, reset         - clock, synchronous active-high reset
//            redirect, redirect_addr - taken jump/branch and its target
//            imem_req/addr/gnt     - memory request channel
//            imem_rvalid/rdata     - memory response channel (in order)
//            inst_valid/inst/inst_pc/inst_ready - decode-side handshake
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int          CNT_W    = 4;  // holds 0..8
    localparam int          PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_W  = 5'(DEPTH);
    localparam logic [31:0] WORD_MSK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_AL = RESET_PC & WORD_MSK;

    // Architectural state
    logic [31:0]      fetch_q, fetch_d;
    logic [31:0]      resp_q, resp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] disc_q, disc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];
    // High for the first cycle after reset so no request issues in that cycle
    logic             init_q;

    logic [4:0]       used;
    logic             grant;
    logic             rsp_drop;
    logic             rsp_take;
    logic             push;
    logic             pop;
    logic [31:0]      target;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        target    = redirect_addr & WORD_MSK;

        // Credits cover buffered entries, live requests and responses still
        // owed for flushed requests, so the buffer can never overflow.
        used      = 5'(count_q) + 5'(out_q) + 5'(disc_q);
        imem_req  = ~reset & ~init_q & ~redirect & (used < DEPTH_W);
        imem_addr = fetch_q;
        grant     = imem_req & imem_gnt;

        // Responses owed to flushed requests drain first; a response with
        // nothing owed and nothing outstanding is spurious and ignored.
        rsp_drop  = imem_rvalid & (disc_q != '0);
        rsp_take  = imem_rvalid & (disc_q == '0) & (out_q != '0);

        inst_valid = ~reset & (count_q != '0);
        inst       = inst_valid ? data_q[head_q] : '0;
        inst_pc    = inst_valid ? pc_q[head_q]   : '0;
        pop        = inst_valid & inst_ready;
        push       = rsp_take & ~redirect;

        fetch_d = fetch_q;
        resp_d  = resp_q;
        count_d = count_q;
        out_d   = out_q;
        disc_d  = disc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        data_d  = data_q;
        pc_d    = pc_q;

        if (redirect) begin
            fetch_d = target;
            resp_d  = target;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            out_d   = '0;
            // Everything still in flight becomes owed; a response landing in
            // this very cycle settles one of those debts immediately.
            disc_d  = disc_q + out_q - CNT_W'(rsp_drop | rsp_take);
        end else begin
            if (grant) begin
                fetch_d = fetch_q + 32'd4;
            end
            out_d  = out_q + CNT_W'(grant) - CNT_W'(rsp_take);
            disc_d = disc_q - CNT_W'(rsp_drop);
            if (push) begin
                data_d[tail_q] = imem_rdata;
                pc_d[tail_q]   = resp_q;
                tail_d         = ptr_inc(tail_q);
                resp_d         = resp_q + 32'd4;
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_q <= RESET_AL;
            resp_q  <= RESET_AL;
            count_q <= '0;
            out_q   <= '0;
            disc_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            init_q  <= 1'b1;
        end else begin
            fetch_q <= fetch_d;
            resp_q  <= resp_d;
            count_q <= count_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            init_q  <= 1'b0;
        end
    end

    // Payload storage needs no reset: outputs are masked while the buffer is empty.
    always_ff @(posedge clock) begin
        data_q <= data_d;
        pc_q   <= pc_d;
    end

endmodule
`default_nettype wire
